edge_hgrad_engine: RTL and testbench

Edge-detection compute engine sitting directly downstream of the accelerator's MMIO register block. It consumes start/clear/base/width/height and returns done. On start it walks the 8-bit greyscale image in memory over an OBI manager port, one 32-bit word (4 pixels) at a time. For each word it computes the horizontal gradient magnitude per pixel, thresholds it, and writes the result word to an output buffer at a fixed offset from the image base.

---
 rtl/edge_pkg.sv | 23 ++
 rtl/edge_hgrad_word.sv | 41 ++++
 rtl/edge_hgrad_engine.sv | 208 ++++++++++++++++++++
 tb/tb_edge_hgrad_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the horizontal-gradient edge engine.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package edge_pkg;

  localparam int PixelW     = 8;
  localparam int PixPerWord = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } edge_state_e;

  // Words per row: a partially filled last word still costs a full word.
  function automatic logic [15:0] ceil_div4(input logic [15:0] n);
    return 16'((17'(n) + 17'd3) >> 2);
  endfunction

endpackage

// File: rtl/edge_hgrad_word.sv
// Per-word horizontal gradient magnitude and threshold, four 8-bit lanes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module edge_hgrad_word
  import edge_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [7:0]  prev_i,
  input  logic        row_first_i,
  input  logic [7:0]  thresh_i,
  output logic [31:0] result_o,
  output logic [7:0]  prev_o
);

  logic [PixelW-1:0] lane0_left;
  logic [31:0]       left_vec;

  // At the start of a row lane 0 is compared with itself so its gradient is 0.
  assign lane0_left = row_first_i ? word_i[7:0] : prev_i;
  // Left neighbour of lane k sits at byte k of this vector.
  assign left_vec   = {word_i[23:0], lane0_left};

  for (genvar k = 0; k < PixPerWord; k++) begin : g_lane
    logic [PixelW-1:0] pix;
    logic [PixelW-1:0] left;
    logic signed [8:0] diff;
    logic [PixelW-1:0] mag;

    assign pix  = word_i[k*PixelW +: PixelW];
    assign left = left_vec[k*PixelW +: PixelW];
    assign diff = $signed({1'b0, pix}) - $signed({1'b0, left});
    assign mag  = diff[8] ? 8'(-diff) : diff[7:0];
    // A zero threshold passes the raw magnitude through.
    assign result_o[k*PixelW +: PixelW] =
        (thresh_i == 8'd0) ? mag : ((mag >= thresh_i) ? 8'hFF : 8'h00);
  end

  // Lane 3 feeds lane 0 of the next word in the same row.
  assign prev_o = word_i[31:24];

endmodule

// File: rtl/edge_hgrad_engine.sv
// Walks a greyscale image over OBI, writing thresholded horizontal gradients.
// Latency: 4 cycles per word minimum (read req, read rsp, write req, write rsp).
// Backpressure: request held stable until gnt; one transaction outstanding.
module edge_hgrad_engine
  import edge_pkg::*;
#(
  parameter logic [31:0] OutOffset = 32'h0000_1000,
  parameter logic [7:0]  Threshold = 8'd32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        clear_i,
  output logic        done_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic [31:0] img_base_addr_i,
  input  logic [15:0] img_width_i,
  input  logic [15:0] img_height_i,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i
);

  edge_state_e state_q, state_d;

  logic [31:0] base_q;
  logic [15:0] wpr_q;
  logic [15:0] height_q;
  logic [15:0] col_q;
  logic [15:0] row_q;
  logic [29:0] idx_q;
  logic [7:0]  prev_q;
  logic [31:0] result_q;
  logic        abort_q;
  logic        err_q;

  logic [31:0] grad_word;
  logic [7:0]  grad_prev;
  logic        idle_like;
  logic        start_acc;
  logic        zero_dim;
  logic        col_wrap;
  logic        last_word;
  logic        abort_now;
  logic        row_first;
  logic [31:0] word_off;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // Clear beats start when both arrive together.
  assign start_acc = idle_like && start_i && !clear_i;
  assign zero_dim  = (img_width_i == 16'd0) || (img_height_i == 16'd0);
  assign col_wrap  = (col_q == wpr_q - 16'd1);
  assign last_word = col_wrap && (row_q == height_q - 16'd1);
  // A clear arriving in the very cycle of a response aborts immediately.
  assign abort_now = abort_q || clear_i;
  assign row_first = (col_q == 16'd0);
  assign word_off  = {idx_q, 2'b00};

  assign busy_o   = !idle_like;
  assign done_o   = (state_q == ST_DONE);
  assign err_o    = err_q;
  assign obi_be_o = 4'hF;

  edge_hgrad_word u_word (
    .word_i      (obi_rdata_i),
    .prev_i      (prev_q),
    .row_first_i (row_first),
    .thresh_i    (Threshold),
    .result_o    (grad_word),
    .prev_o      (grad_prev)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and OBI request outputs; outputs depend only on registered state.
  always_comb begin
    state_d     = state_q;
    obi_req_o   = 1'b0;
    obi_we_o    = 1'b0;
    obi_addr_o  = 32'h0;
    obi_wdata_o = 32'h0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (clear_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = zero_dim ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        obi_req_o  = 1'b1;
        obi_addr_o = (base_q + word_off) & 32'hFFFF_FFFC;
        if (obi_gnt_i) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (obi_rvalid_i) begin
          if (abort_now) begin
            state_d = ST_IDLE;
          end else if (obi_err_i) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        obi_req_o   = 1'b1;
        obi_we_o    = 1'b1;
        obi_addr_o  = (base_q + OutOffset + word_off) & 32'hFFFF_FFFC;
        obi_wdata_o = result_q;
        if (obi_gnt_i) begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (obi_rvalid_i) begin
          if (abort_now) begin
            state_d = ST_IDLE;
          end else if (obi_err_i || last_word) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job registers, position counters, result capture, abort and error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q   <= 32'h0;
      wpr_q    <= 16'h0;
      height_q <= 16'h0;
      col_q    <= 16'h0;
      row_q    <= 16'h0;
      idx_q    <= 30'h0;
      prev_q   <= 8'h0;
      result_q <= 32'h0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q   <= img_base_addr_i;
        wpr_q    <= ceil_div4(img_width_i);
        height_q <= img_height_i;
        col_q    <= 16'h0;
        row_q    <= 16'h0;
        idx_q    <= 30'h0;
        prev_q   <= 8'h0;
        err_q    <= 1'b0;
      end

      if (clear_i) begin
        err_q <= 1'b0;
        if (!idle_like) begin
          abort_q <= 1'b1;
        end
      end

      if (state_q == ST_RD_WAIT && obi_rvalid_i) begin
        if (obi_err_i) begin
          err_q <= 1'b1;
        end else begin
          result_q <= grad_word;
          prev_q   <= grad_prev;
        end
      end

      if (state_q == ST_WR_WAIT && obi_rvalid_i) begin
        if (obi_err_i) begin
          err_q <= 1'b1;
        end else if (!last_word && !abort_now) begin
          idx_q <= idx_q + 30'd1;
          if (col_wrap) begin
            col_q <= 16'h0;
            row_q <= row_q + 16'd1;
          end else begin
            col_q <= col_q + 16'd1;
          end
        end
      end

      // Any return to idle retires a pending abort.
      if (state_d == ST_IDLE) begin
        abort_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_hgrad_engine.sv
// Randomized scoreboard bench for edge_hgrad_engine with an OBI memory responder.
// Latency: checks 4 cycles per word with zero-wait grant and single-cycle response.
// Backpressure: responder inserts grant and response delays, optionally fixed.
module tb_edge_hgrad_engine;

  localparam logic [31:0] OFF = 32'h0000_1000;
  localparam int          THR = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        done_o, busy_o, err_o;
  logic [31:0] img_base_addr_i = 32'h0;
  logic [15:0] img_width_i = 16'h0;
  logic [15:0] img_height_i = 16'h0;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = 32'h0;
  logic        obi_err_i = 1'b0;

  always #5 clk_i = ~clk_i;

  edge_hgrad_engine dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .clear_i         (clear_i),
    .done_o          (done_o),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .img_base_addr_i (img_base_addr_i),
    .img_width_i     (img_width_i),
    .img_height_i    (img_height_i),
    .obi_req_o       (obi_req_o),
    .obi_gnt_i       (obi_gnt_i),
    .obi_addr_o      (obi_addr_o),
    .obi_we_o        (obi_we_o),
    .obi_be_o        (obi_be_o),
    .obi_wdata_o     (obi_wdata_o),
    .obi_rvalid_i    (obi_rvalid_i),
    .obi_rdata_i     (obi_rdata_i),
    .obi_err_i       (obi_err_i)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  xact_t       exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int gnt_fix  = -1;
  int lat_fix  = -1;
  int err_rd_at = -1;
  int rd_seen  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference: per-lane |pixel - left neighbour|, then threshold.
  function automatic logic [31:0] ref_word(input logic [31:0] w, input int left, input bit first);
    int p[4];
    int prv, g, v;
    logic [31:0] o;
    o = 32'h0;
    for (int k = 0; k < 4; k++) p[k] = int'((w >> (8 * k)) & 32'hFF);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) prv = first ? p[0] : left;
      else        prv = p[k-1];
      g = (p[k] > prv) ? p[k] - prv : prv - p[k];
      if (THR == 0) v = g;
      else          v = (g >= THR) ? 255 : 0;
      o = o | (32'(v) << (8 * k));
    end
    return o;
  endfunction

  // Push the expected reads and writes for a job; stop after max_words or at an erroring read.
  task automatic plan_job(input logic [31:0] base, input int w, input int h, input int max_words,
                          input int err_rd, output int er, output int ew);
    int wpr, idx, left;
    logic [31:0] a, word;
    xact_t x;
    wpr = (w + 3) / 4;
    idx = 0; left = 0; er = 0; ew = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < wpr; c++) begin
        if (idx >= max_words) return;
        a = base + 32'(4 * idx);
        exp_rd_q.push_back(a);
        er++;
        if (idx == err_rd) return;
        word = mem_rd(a);
        x.addr = a + OFF;
        x.data = ref_word(word, left, c == 0);
        exp_wr_q.push_back(x);
        ew++;
        left = int'(word[31:24]);
        idx++;
      end
    end
  endtask

  // OBI memory responder: delayed grant, delayed response, optional read error.
  initial begin : responder
    bit          pend;
    bit          pend_err;
    logic [31:0] pend_dat;
    int          lat;
    bit          gact;
    int          gcnt;
    pend = 0; pend_err = 0; pend_dat = 32'h0; lat = 0; gact = 0; gcnt = 0;
    forever begin
      @(posedge clk_i); #1;
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = 32'h0;
      if (!rst_ni) begin
        pend = 0; gact = 0;
      end else if (pend) begin
        if (lat == 0) begin
          obi_rvalid_i = 1'b1; obi_rdata_i = pend_dat; obi_err_i = pend_err; pend = 0;
        end else lat--;
      end else if (obi_req_o) begin
        if (!gact) begin
          gact = 1;
          gcnt = (gnt_fix >= 0) ? gnt_fix : int'($urandom_range(0, 3));
        end
        if (gcnt == 0) begin
          obi_gnt_i = 1'b1; gact = 0; pend = 1;
          lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 2));
          pend_err = 0;
          pend_dat = $urandom;
          if (!obi_we_o) begin
            pend_dat = mem_rd(obi_addr_o);
            pend_err = (rd_seen == err_rd_at);
            rd_seen++;
          end
        end else gcnt--;
      end
    end
  end

  // Monitor: request stability while waiting, and scoreboard compare on each accepted transaction.
  initial begin : monitor
    bit          hold_v;
    logic [31:0] h_addr;
    logic [32:0] h_wd;
    xact_t       x;
    logic [31:0] ra;
    hold_v = 0; h_addr = 32'h0; h_wd = 33'h0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && obi_req_o) begin
        if (hold_v) begin
          chk("req_addr_stable", obi_addr_o, h_addr);
          chk("req_we_wdata_stable", {obi_we_o, obi_wdata_o}, h_wd);
        end
        hold_v = !obi_gnt_i;
        h_addr = obi_addr_o;
        h_wd   = {obi_we_o, obi_wdata_o};
        if (obi_gnt_i) begin
          chk("obi_be", obi_be_o, 4'hF);
          if (obi_we_o) begin
            n_wr++;
            if (exp_wr_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", obi_addr_o, obi_wdata_o);
            end else begin
              x = exp_wr_q.pop_front();
              chk("write_addr", obi_addr_o, x.addr);
              chk("write_data", obi_wdata_o, x.data);
            end
          end else begin
            n_rd++;
            if (exp_rd_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_read: addr 0x%0h, expected no read", obi_addr_o);
            end else begin
              ra = exp_rd_q.pop_front();
              chk("read_addr", obi_addr_o, ra);
            end
          end
        end
      end else hold_v = 0;
    end
  end

  task automatic pulse_start(input logic [31:0] base, input int w, input int h);
    @(posedge clk_i); #1;
    img_base_addr_i = base; img_width_i = 16'(w); img_height_i = 16'(h);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    img_base_addr_i = $urandom; img_width_i = 16'($urandom); img_height_i = 16'($urandom);
  endtask

  task automatic run_job(input logic [31:0] base, input int w, input int h, input int err_rd,
                         input logic exp_err, output int cyc);
    int er, ew, rd0, wr0;
    plan_job(base, w, h, 1 << 30, err_rd, er, ew);
    rd0 = n_rd; wr0 = n_wr; rd_seen = 0; err_rd_at = err_rd;
    pulse_start(base, w, h);
    @(negedge clk_i);
    chk("busy_after_start", busy_o, 1);
    chk("done_cleared_by_start", done_o, 0);
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("job_done", done_o, 1);
    chk("job_err", err_o, exp_err);
    chk("job_not_busy", busy_o, 0);
    chk("job_reads", 64'(n_rd - rd0), 64'(er));
    chk("job_writes", 64'(n_wr - wr0), 64'(ew));
    chk("job_queues_drained", 64'(exp_rd_q.size() + exp_wr_q.size()), 0);
    err_rd_at = -1;
  endtask

  initial begin : main
    int cyc, er, ew, rd0, wr0, reqs;
    logic [31:0] base;
    int w, h;

    // Reset values.
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", obi_req_o, 0);
    chk("rst_we", obi_we_o, 0);
    chk("rst_addr", obi_addr_o, 0);
    chk("rst_wdata", obi_wdata_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Two-word single row, carry of lane 3 into the next word.
    mem[32'h100] = 32'h4030_2010;
    mem[32'h104] = 32'h0000_0050;
    run_job(32'h100, 8, 1, -1, 1'b0, cyc);

    // Two rows: no carry across the row boundary.
    mem[32'h200] = 32'h0000_0080;
    mem[32'h204] = 32'h8080_8080;
    run_job(32'h200, 4, 2, -1, 1'b0, cyc);

    // Grant held low 5 cycles, then an error on the first read: no write.
    gnt_fix = 5;
    run_job(32'h100, 8, 1, 0, 1'b1, cyc);
    gnt_fix = -1;

    // Zero height: done the next cycle with no bus traffic.
    rd0 = n_rd; wr0 = n_wr;
    pulse_start(32'h100, 8, 0);
    @(negedge clk_i);
    chk("zero_dim_done", done_o, 1);
    chk("zero_dim_busy", busy_o, 0);
    repeat (10) @(negedge clk_i);
    chk("zero_dim_no_req", 64'((n_rd - rd0) + (n_wr - wr0)), 0);

    // Clear while the first write waits for grant; an extra start is ignored.
    gnt_fix = 5;
    for (int i = 0; i < 4; i++) mem[32'h300 + 32'(4 * i)] = $urandom;
    plan_job(32'h300, 16, 1, 1, -1, er, ew);
    rd0 = n_rd; wr0 = n_wr;
    pulse_start(32'h300, 16, 1);
    cyc = 0;
    while (!(obi_req_o && obi_we_o) && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("clr_reached_wr_req", {obi_req_o, obi_we_o}, 2'b11);
    @(posedge clk_i); #1; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0; clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("clr_idle", busy_o, 0);
    chk("clr_done_low", done_o, 0);
    chk("clr_err_low", err_o, 0);
    chk("clr_reads", 64'(n_rd - rd0), 64'(er));
    chk("clr_writes", 64'(n_wr - wr0), 64'(ew));
    reqs = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (obi_req_o) reqs++;
    end
    chk("clr_no_further_req", 64'(reqs), 0);
    chk("clr_queues_drained", 64'(exp_rd_q.size() + exp_wr_q.size()), 0);
    gnt_fix = -1;

    // Randomized images with random grant/response delays.
    for (int j = 0; j < 8; j++) begin
      base = 32'h4000 + 32'(j * 32'h200);
      w = int'($urandom_range(1, 21));
      h = int'($urandom_range(1, 4));
      for (int i = 0; i < 24; i++) mem[base + 32'(4 * i)] = $urandom;
      run_job(base, w, h, -1, 1'b0, cyc);
    end

    // Zero-wait bus: four words must take 16 cycles.
    gnt_fix = 0; lat_fix = 0;
    for (int i = 0; i < 4; i++) mem[32'h6000 + 32'(4 * i)] = $urandom;
    run_job(32'h6000, 16, 1, -1, 1'b0, cyc);
    chk("throughput_cycles", 64'(cyc), 16);

    // Clear from DONE returns to idle with done low.
    @(posedge clk_i); #1; clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
    @(negedge clk_i);
    chk("clear_from_done", done_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
